pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl_pkg.sv | 36 +++
 rtl/pipe_hazard_ctrl_mdu_busy_timer.sv | 78 +++++++
 rtl/pipe_hazard_ctrl.sv | 80 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller and the MDU timing logic.
package pipe_hazard_ctrl_pkg;

    // Tuse/Tnew encodings: Tuse of 3 means the operand is never read.
    localparam logic [1:0] TUSE_NONE  = 2'd3;
    localparam logic [1:0] TNEW_READY = 2'd0;

    // Default MDU latencies, also used by the MDU datapath.
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // MDU sequencing states.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    // A source register stalls when an in-flight producer of the same
    // register will not have its result ready by the time ID needs it.
    // Register 0 is hard-wired and never causes a stall.
    function automatic logic reg_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] ex_wa,
        input logic [1:0] ex_tnew,
        input logic [4:0] mem_wa,
        input logic [1:0] mem_tnew
    );
        logic ex_hit;
        logic mem_hit;
        ex_hit  = (src == ex_wa)  && (ex_tnew  > tuse);
        mem_hit = (src == mem_wa) && (mem_tnew > tuse);
        return (src != 5'd0) && (ex_hit || mem_hit);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_mdu_busy_timer.sv
// MDU busy countdown: loads the op latency on start, counts down while busy
// and raises a registered done pulse during the last busy cycle.
module mdu_busy_timer
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    mdu_state_e state_r;
    mdu_state_e state_next_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_next_s;
    logic       busy_r;
    logic       done_r;
    logic       done_next_s;

    // Next-state logic: a start while busy is ignored; done is asserted for
    // the cycle in which the counter holds 1.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        done_next_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = BUSY;
                    cnt_next_s   = is_div ? DIV_LOAD : MULT_LOAD;
                    done_next_s  = (cnt_next_s == 4'd1);
                end else begin
                    cnt_next_s   = 4'd0;
                end
            end
            BUSY: begin
                if (cnt_r == 4'd1) begin
                    state_next_s = IDLE;
                    cnt_next_s   = 4'd0;
                end else begin
                    cnt_next_s   = cnt_r - 4'd1;
                    done_next_s  = (cnt_r == 4'd2);
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // State, counter and registered status outputs; reset aborts any op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            busy_r  <= (state_next_s == BUSY);
            done_r  <= done_next_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler: data-hazard checks on rs/rt against EX and
// MEM producers, MDU-busy interlock, and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic [1:0]  ID_Tuse_rs,
    input  logic [1:0]  ID_Tuse_rt,
    input  logic        ID_is_mdu,
    input  logic [4:0]  EX_wa,
    input  logic [1:0]  EX_Tnew,
    input  logic [4:0]  MEM_wa,
    input  logic [1:0]  MEM_Tnew,
    input  logic        EX_mdu_start,
    input  logic        EX_mdu_div,
    output logic        PC_WE,
    output logic        IF_ID_WE,
    output logic        ID_EX_flush,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic [31:0] stall_cnt
);

    logic        busy_s;
    logic        done_s;
    logic        stall_rs_s;
    logic        stall_rt_s;
    logic        stall_mdu_s;
    logic        stall_s;
    logic [31:0] stall_cnt_r;

    mdu_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_mdu_busy_timer (
        .clk    (clk),
        .rst_n  (reset),
        .start  (EX_mdu_start),
        .is_div (EX_mdu_div),
        .busy   (busy_s),
        .done   (done_s)
    );

    // Hazard detection; in reset the pipeline is never held.
    always_comb begin
        stall_rs_s  = reg_hazard(ID_rs, ID_Tuse_rs, EX_wa, EX_Tnew, MEM_wa, MEM_Tnew);
        stall_rt_s  = reg_hazard(ID_rt, ID_Tuse_rt, EX_wa, EX_Tnew, MEM_wa, MEM_Tnew);
        stall_mdu_s = ID_is_mdu && (EX_mdu_start || busy_s);
        if (reset) begin
            stall_s = stall_rs_s || stall_rt_s || stall_mdu_s;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign PC_WE       = ~stall_s;
    assign IF_ID_WE    = ~stall_s;
    assign ID_EX_flush = stall_s;
    assign mdu_busy    = busy_s;
    assign mdu_done    = done_s;
    assign stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the driver computes expected
// per-cycle outputs from a behavioural model and queues them; a monitor
// pops and compares once per cycle.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  ID_rs = 5'd0;
    logic [4:0]  ID_rt = 5'd0;
    logic [1:0]  ID_Tuse_rs = 2'd3;
    logic [1:0]  ID_Tuse_rt = 2'd3;
    logic        ID_is_mdu = 1'b0;
    logic [4:0]  EX_wa = 5'd0;
    logic [1:0]  EX_Tnew = 2'd0;
    logic [4:0]  MEM_wa = 5'd0;
    logic [1:0]  MEM_Tnew = 2'd0;
    logic        EX_mdu_start = 1'b0;
    logic        EX_mdu_div = 1'b0;
    logic        PC_WE;
    logic        IF_ID_WE;
    logic        ID_EX_flush;
    logic        mdu_busy;
    logic        mdu_done;
    logic [31:0] stall_cnt;

    pipe_hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .ID_rs        (ID_rs),
        .ID_rt        (ID_rt),
        .ID_Tuse_rs   (ID_Tuse_rs),
        .ID_Tuse_rt   (ID_Tuse_rt),
        .ID_is_mdu    (ID_is_mdu),
        .EX_wa        (EX_wa),
        .EX_Tnew      (EX_Tnew),
        .MEM_wa       (MEM_wa),
        .MEM_Tnew     (MEM_Tnew),
        .EX_mdu_start (EX_mdu_start),
        .EX_mdu_div   (EX_mdu_div),
        .PC_WE        (PC_WE),
        .IF_ID_WE     (IF_ID_WE),
        .ID_EX_flush  (ID_EX_flush),
        .mdu_busy     (mdu_busy),
        .mdu_done     (mdu_done),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pc_we;
        logic        ifid_we;
        logic        flush;
        logic        busy;
        logic        done;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: remaining MDU busy cycles and the stall count.
    int          rem = 0;
    logic [31:0] m_cnt = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // A consumer must wait when a matching producer needs more cycles than
    // the consumer can afford; register 0 is never a real dependency.
    function automatic bit must_wait(input int src, input int tuse, input int ewa, input int et,
                                     input int mwa, input int mt);
        if (src == 0) return 1'b0;
        return (src == ewa && et > tuse) || (src == mwa && mt > tuse);
    endfunction

    // One clock of stimulus: drive, predict this cycle, advance the model.
    task automatic step(input logic rst, input logic [4:0] rs, input logic [1:0] tur,
                        input logic [4:0] rt, input logic [1:0] tut, input logic mdu,
                        input logic [4:0] ewa, input logic [1:0] et,
                        input logic [4:0] mwa, input logic [1:0] mt,
                        input logic st, input logic dv);
        exp_t e;
        bit   stall;
        @(negedge clk);
        reset = rst; ID_rs = rs; ID_Tuse_rs = tur; ID_rt = rt; ID_Tuse_rt = tut;
        ID_is_mdu = mdu; EX_wa = ewa; EX_Tnew = et; MEM_wa = mwa; MEM_Tnew = mt;
        EX_mdu_start = st; EX_mdu_div = dv;
        #1;
        if (!rst) begin
            rem   = 0;
            m_cnt = 32'd0;
        end
        stall = rst && (must_wait(rs, tur, ewa, et, mwa, mt) || must_wait(rt, tut, ewa, et, mwa, mt)
                        || (mdu && (st || rem > 0)));
        e.pc_we   = !stall;
        e.ifid_we = !stall;
        e.flush   = stall;
        e.busy    = (rem > 0);
        e.done    = (rem == 1);
        e.cnt     = m_cnt;
        exp_q.push_back(e);
        if (rst) begin
            if (stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (rem > 0) rem = rem - 1;
            else if (st) rem = dv ? 10 : 5;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    endtask

    // Monitor: compares every queued expectation mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("PC_WE",       32'(PC_WE),       32'(e.pc_we));
                check("IF_ID_WE",    32'(IF_ID_WE),    32'(e.ifid_we));
                check("ID_EX_flush", 32'(ID_EX_flush), 32'(e.flush));
                check("mdu_busy",    32'(mdu_busy),    32'(e.busy));
                check("mdu_done",    32'(mdu_done),    32'(e.done));
                check("stall_cnt",   stall_cnt,        e.cnt);
            end
        end
    end

    initial begin
        int waited;
        // Reset held with hazard-looking inputs: no stall may show.
        step(1'b0, 5'd5, 2'd0, 5'd0, 2'd3, 1'b1, 5'd5, 2'd1, 5'd0, 2'd0, 1'b1, 1'b0);
        step(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        idle(2);
        // Load-use on rs, then the same producer against register 0.
        step(1'b1, 5'd5, 2'd0, 5'd0, 2'd3, 1'b0, 5'd5, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0);
        step(1'b1, 5'd0, 2'd0, 5'd0, 2'd3, 1'b0, 5'd5, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0);
        // MEM producer vs rt: Tnew == Tuse passes, Tnew > Tuse stalls.
        step(1'b1, 5'd0, 2'd3, 5'd7, 2'd1, 1'b0, 5'd0, 2'd0, 5'd7, 2'd1, 1'b0, 1'b0);
        step(1'b1, 5'd0, 2'd3, 5'd7, 2'd0, 1'b0, 5'd0, 2'd0, 5'd7, 2'd1, 1'b0, 1'b0);
        // EX and MEM on the same register: only MEM is late.
        step(1'b1, 5'd9, 2'd1, 5'd0, 2'd3, 1'b0, 5'd9, 2'd0, 5'd9, 2'd2, 1'b0, 1'b0);
        idle(1);
        // mult with an MDU instruction held in ID throughout.
        step(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++)
            step(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        idle(1);
        // div with a spurious second start on busy cycle 3.
        step(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1);
        for (int k = 1; k <= 12; k++)
            step(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, k == 3, 1'b0);
        // Reset on busy cycle 4 of a div, with an MDU stall in progress.
        step(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b1, 1'b1);
        for (int k = 1; k <= 3; k++)
            step(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        idle(12);
        // Saturation: preload the counter just below the top, then stall 3 cycles.
        @(negedge clk);
        force dut.stall_cnt_r = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_r;
        m_cnt = 32'hFFFF_FFFE;
        for (int k = 0; k < 3; k++)
            step(1'b1, 5'd5, 2'd0, 5'd0, 2'd3, 1'b0, 5'd5, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0);
        idle(2);
        // Randomised traffic over a small register set to provoke collisions.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(63) != 0),
                 5'($urandom_range(3)), 2'($urandom_range(3)),
                 5'($urandom_range(3)), 2'($urandom_range(3)),
                 1'($urandom_range(1)),
                 5'($urandom_range(3)), 2'($urandom_range(3)),
                 5'($urandom_range(3)), 2'($urandom_range(3)),
                 ($urandom_range(7) == 0), 1'($urandom_range(1)));
        end
        idle(2);
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        #5;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
